stream_dot: RTL and testbench

Signed dot-product reducer that sits directly downstream of `stream_join`. It consumes joined beats `{a, b}`, multiplies each pair, and accumulates `K_LEN` consecutive products. It emits one result beat per `K_LEN` input beats on a valid/ready stream. Both ports use standard valid/ready handshakes, and the block sustains full throughput (one input beat per cycle).

---
 rtl/stream_dot.sv | 134 +++++++++++++
 tb/tb_stream_dot.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_dot.sv
// stream_dot: signed dot-product reducer; multiplies joined {a, b} beats and emits one sum per K_LEN beats.
// Build option: define STREAM_DOT_SAT_EN to clamp the result to the signed OUT_WIDTH range instead of wrapping.
module stream_dot #(
    parameter int unsigned A_WIDTH   = 8,
    parameter int unsigned B_WIDTH   = 8,
    parameter int unsigned K_LEN     = 4,
    parameter int unsigned ACC_WIDTH = A_WIDTH + B_WIDTH + $clog2(K_LEN),
    parameter int unsigned OUT_WIDTH = ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_valid,
    output logic                         i_ready,
    input  logic [A_WIDTH+B_WIDTH-1:0]   i_data,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [OUT_WIDTH-1:0]         o_data
);

    localparam int unsigned P_WIDTH   = A_WIDTH + B_WIDTH;
    localparam int unsigned CNT_WIDTH = $clog2(K_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(K_LEN - 1);

    logic signed [A_WIDTH-1:0]   op_a;
    logic signed [B_WIDTH-1:0]   op_b;
    logic signed [P_WIDTH-1:0]   prod_c;
    logic                        in_hs_c;
    logic                        stage2_take_c;
    logic signed [ACC_WIDTH-1:0] p_ext_c;
    logic signed [ACC_WIDTH-1:0] sum_c;
    logic [OUT_WIDTH-1:0]        out_c;

    logic [CNT_WIDTH-1:0]        cnt;
    logic                        p_valid;
    logic                        p_last;
    logic signed [P_WIDTH-1:0]   p_data;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        acc_busy;

    assign op_a   = i_data[P_WIDTH-1:B_WIDTH];
    assign op_b   = i_data[B_WIDTH-1:0];
    assign prod_c = P_WIDTH'(op_a) * P_WIDTH'(op_b);

    // A stalled last product is the only thing that blocks stage 2, so i_ready never looks at i_valid.
    assign stage2_take_c = p_valid && !(p_last && o_valid && !o_ready);
    assign i_ready       = !p_valid || stage2_take_c;
    assign in_hs_c       = i_valid && i_ready;

    assign p_ext_c = ACC_WIDTH'(p_data);
    assign sum_c   = acc_busy ? (acc + p_ext_c) : p_ext_c;

`ifdef STREAM_DOT_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // Clamp to the signed output range.
    always_comb begin
        out_c = sum_c[OUT_WIDTH-1:0];
        if (sum_c > SAT_MAX) begin
            out_c = SAT_MAX[OUT_WIDTH-1:0];
        end else if (sum_c < SAT_MIN) begin
            out_c = SAT_MIN[OUT_WIDTH-1:0];
        end
    end
`else
    // Two's complement wrap: keep the low bits.
    always_comb begin
        out_c = sum_c[OUT_WIDTH-1:0];
    end
`endif

    // Element counter, wraps after the last element of a vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (in_hs_c) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Stage 1: product register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p_data  <= '0;
        end else begin
            if (in_hs_c) begin
                p_valid <= 1'b1;
                p_last  <= (cnt == CNT_LAST);
                p_data  <= prod_c;
            end else if (stage2_take_c) begin
                p_valid <= 1'b0;
            end
        end
    end

    // Stage 2: accumulate; the last product goes straight to the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            acc_busy <= 1'b0;
        end else if (stage2_take_c) begin
            if (p_last) begin
                acc_busy <= 1'b0;
            end else begin
                acc      <= sum_c;
                acc_busy <= 1'b1;
            end
        end
    end

    // Output register; a new result may replace the one being consumed on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            if (stage2_take_c && p_last) begin
                o_valid <= 1'b1;
                o_data  <= out_c;
            end else if (o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_dot.sv
// Bench for stream_dot: a default-width DUT and an OUT_WIDTH=16 DUT share the same stimulus.
module tb_stream_dot;

    localparam int unsigned AW   = 8;
    localparam int unsigned BW   = 8;
    localparam int unsigned K    = 4;
    localparam int unsigned ACCW = AW + BW + $clog2(K);
    localparam int unsigned OW16 = 16;

    logic            clk     = 1'b0;
    logic            reset   = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready = 1'b0;
    logic [AW+BW-1:0] i_data = '0;
    logic            i_ready, i_ready16;
    logic            o_valid, o_valid16;
    logic [ACCW-1:0] o_data;
    logic [OW16-1:0] o_data16;

    int errors = 0;
    int checks = 0;
    bit rand_ordy = 1'b0;
    int rd = 0;

    logic [ACCW-1:0] obs_q[$];
    logic [OW16-1:0] obs16_q[$];

    always #5 clk = ~clk;

    stream_dot #(.A_WIDTH(AW), .B_WIDTH(BW), .K_LEN(K)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
    );

    stream_dot #(.A_WIDTH(AW), .B_WIDTH(BW), .K_LEN(K), .OUT_WIDTH(OW16)) dut16 (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready16), .i_data(i_data),
        .o_valid(o_valid16), .o_ready(o_ready), .o_data(o_data16)
    );

    // Record every consumed result; the handshake completes on the following rising edge.
    always @(negedge clk) begin
        if (reset && o_valid && o_ready) obs_q.push_back(o_data);
        if (reset && o_valid16 && o_ready) obs16_q.push_back(o_data16);
    end

    // Reference reduction of an exact integer sum to an ow-bit result, returned as raw bits.
    function automatic longint reduce(input longint s, input int ow);
        longint r;
        r = s;
`ifdef STREAM_DOT_SAT_EN
        if (r > (longint'(1) << (ow - 1)) - 1) r = (longint'(1) << (ow - 1)) - 1;
        if (r < -(longint'(1) << (ow - 1)))    r = -(longint'(1) << (ow - 1));
`endif
        return r & ((longint'(1) << ow) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ordy) o_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int a, input int b);
        bit done;
        done    = 1'b0;
        i_valid = 1'b1;
        i_data  = {AW'(a), BW'(b)};
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = i_ready;
            tick();
        end
        i_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout beat=(%0d,%0d) got i_ready=0 for 200 cycles, want 1", a, b);
        end
    endtask

    task automatic drain(input int n_exp);
        rand_ordy = 1'b0;
        o_ready   = 1'b1;
        for (int t = 0; t < 100 && obs_q.size() < rd + n_exp; t++) tick();
        for (int t = 0; t < 4; t++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) reset = 1'b1;
            tick();
            checks++;
            if (o_valid !== 1'b0 || o_data !== '0 || i_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got o_valid=%b o_data=%0d i_ready=%b, want 0 0 1",
                         c, o_valid, o_data, i_ready);
            end
        end
    endtask

    task automatic test_basic();
        int pa[4] = '{1, 3, 5, 7};
        int pb[4] = '{2, 4, 6, 8};
        longint s = 0;
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s += longint'(pa[i] * pb[i]);
            send(pa[i], pb[i]);
        end
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got o_valid=%b, want 0", o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || longint'(o_data) !== reduce(s, ACCW)) begin
            errors++;
            $display("FAIL basic_result got valid=%b data=%0d, want 1 %0d", o_valid, o_data, reduce(s, ACCW));
        end
        tick();
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_one_cycle got o_valid=%b, want 0", o_valid);
        end
        checks++;
        if (obs_q.size() != rd + 1) begin
            errors++;
            $display("FAIL basic_count got %0d results, want 1", obs_q.size() - rd);
        end
        rd = obs_q.size();
    endtask

    task automatic test_sat();
        longint s = 0;
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s += longint'(-128 * -128);
            send(-128, -128);
        end
        drain(1);
        checks++;
        if (obs_q.size() != rd + 1 || obs16_q.size() != rd + 1) begin
            errors++;
            $display("FAIL sat_count got %0d/%0d results, want 1", obs_q.size() - rd, obs16_q.size() - rd);
        end else begin
            checks++;
            if (longint'(obs16_q[rd]) !== reduce(s, OW16)) begin
                errors++;
                $display("FAIL sat_out16 got %0d, want %0d", obs16_q[rd], reduce(s, OW16));
            end
            checks++;
            if (longint'(obs_q[rd]) !== reduce(s, ACCW)) begin
                errors++;
                $display("FAIL sat_full got %0d, want %0d", obs_q[rd], reduce(s, ACCW));
            end
        end
        rd = obs_q.size();
    endtask

    task automatic test_stall();
        int acc_cnt = 0;
        bit hs;
        o_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2 * i + 1, 2 * i + 2);
        tick();
        tick();
        i_valid = 1'b1;
        i_data  = {AW'(1), BW'(1)};
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            hs = i_valid && i_ready;
            checks++;
            if (o_valid !== 1'b1 || o_data !== ACCW'(100)) begin
                errors++;
                $display("FAIL stall_hold t=%0d got valid=%b data=%0d, want 1 100", t, o_valid, o_data);
            end
            tick();
            if (hs) acc_cnt++;
            if (acc_cnt == K) i_valid = 1'b0;
        end
        checks++;
        if (acc_cnt != K || i_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_accept got accepted=%0d i_ready=%b, want %0d 0", acc_cnt, i_ready, K);
        end
        o_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== ACCW'(100)) begin
            errors++;
            $display("FAIL stall_first got valid=%b data=%0d, want 1 100", o_valid, o_data);
        end
        tick();
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b1 || o_data !== ACCW'(4)) begin
            errors++;
            $display("FAIL stall_second got valid=%b data=%0d, want 1 4", o_valid, o_data);
        end
        drain(2);
        checks++;
        if (obs_q.size() != rd + 2) begin
            errors++;
            $display("FAIL stall_count got %0d results, want 2", obs_q.size() - rd);
        end
        rd = obs_q.size();
    endtask

    task automatic test_reset_mid();
        o_ready = 1'b1;
        send(9, 9);
        send(9, 9);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) send(1, 1);
        drain(1);
        checks++;
        if (obs_q.size() != rd + 1 || obs_q[rd] !== ACCW'(4)) begin
            errors++;
            $display("FAIL reset_mid got %0d results first=%0d, want 1 result of 4",
                     obs_q.size() - rd, (obs_q.size() > rd) ? obs_q[rd] : '0);
        end
        rd = obs_q.size();
    endtask

    task automatic test_toggle();
        int pa[4] = '{1, 3, 5, 7};
        int pb[4] = '{2, 4, 6, 8};
        longint s = 0;
        rand_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s += longint'(pa[i] * pb[i]);
            send(pa[i], pb[i]);
            tick();
        end
        drain(1);
        checks++;
        if (obs_q.size() != rd + 1 || longint'(obs_q[rd]) !== reduce(s, ACCW)) begin
            errors++;
            $display("FAIL toggle got %0d results first=%0d, want 1 result of %0d",
                     obs_q.size() - rd, (obs_q.size() > rd) ? obs_q[rd] : '0, reduce(s, ACCW));
        end
        rd = obs_q.size();
    endtask

    task automatic test_random();
        longint sums[$];
        rand_ordy = 1'b1;
        for (int v = 0; v < 8; v++) begin
            longint s = 0;
            for (int i = 0; i < 4; i++) begin
                int a = int'($urandom_range(0, 255)) - 128;
                int b = int'($urandom_range(0, 255)) - 128;
                s += longint'(a * b);
                send(a, b);
                if ($urandom_range(0, 3) == 0) tick();
            end
            sums.push_back(s);
        end
        drain(8);
        checks++;
        if (obs_q.size() != rd + 8 || obs16_q.size() != rd + 8) begin
            errors++;
            $display("FAIL random_count got %0d/%0d results, want 8", obs_q.size() - rd, obs16_q.size() - rd);
        end else begin
            for (int v = 0; v < 8; v++) begin
                checks++;
                if (longint'(obs_q[rd+v]) !== reduce(sums[v], ACCW) ||
                    longint'(obs16_q[rd+v]) !== reduce(sums[v], OW16)) begin
                    errors++;
                    $display("FAIL random_vec%0d got %0d/%0d, want %0d/%0d", v, obs_q[rd+v], obs16_q[rd+v],
                             reduce(sums[v], ACCW), reduce(sums[v], OW16));
                end
            end
        end
        rd = obs_q.size();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat();
        test_stall();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
